// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a registered serializer.
// tx falls one clk after a byte lands in an empty idle block; in_ready low only while the FIFO is full.

module uart_tx_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  output logic                     push_rdy,
  output logic                     pop_vld,
  input  logic                     pop_rdy,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  // Full refuses a push even when a pop happens in the same cycle.
  assign push_rdy = count_q < (AW+1)'(DEPTH);
  assign pop_vld  = count_q != '0;
  assign push     = push_vld && push_rdy;
  assign pop      = pop_rdy && pop_vld;
  assign pop_dat  = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

module uart_tx_fifo #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_fifo: CLK_FREQ/BAUD must be at least 2");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_reg_q, shift_reg_d;
  logic          tx_q, tx_d;
  logic          pop;
  logic          fifo_vld;
  logic [7:0]    fifo_dat;
  logic          bit_end;

  uart_tx_fifo_buf #(.WIDTH(8), .DEPTH(DEPTH)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push_vld (in_valid),
    .push_dat (in_data),
    .push_rdy (in_ready),
    .pop_vld  (fifo_vld),
    .pop_rdy  (pop),
    .pop_dat  (fifo_dat),
    .count    (count)
  );

  assign bit_end = baud_cnt_q == BIT_LAST;
  assign tx      = tx_q;
  assign busy    = (state_q != IDLE) || fifo_vld;

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_reg_d = shift_reg_q;
    tx_d        = tx_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d       = 1'b1;
        baud_cnt_d = '0;
        if (fifo_vld) begin
          pop         = 1'b1;
          shift_reg_d = fifo_dat;
          tx_d        = 1'b0;
          state_d     = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          tx_d       = shift_reg_q[0];
          bit_idx_d  = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_reg_d = shift_reg_q >> 1;
            tx_d        = shift_reg_q[1];
            bit_idx_d   = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          // Chain straight into the next start bit so queued frames abut.
          if (fifo_vld) begin
            pop         = 1'b1;
            shift_reg_d = fifo_dat;
            tx_d        = 1'b0;
            state_d     = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_reg_q <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_reg_q <= shift_reg_d;
      tx_q        <= tx_d;
    end
  end
endmodule
